regfile_wb_queue: RTL and testbench

Write-back queue that collects completed results from the ALU and load unit and drives the 64-bit, 32-entry register file's write port. It accepts up to two results per cycle through valid/ready handshakes, buffers them in order, and issues one register write per cycle. It also provides a forwarding lookup so decode can read results that are queued but not yet written into the register file.

---
 rtl/regfile_wb_queue.sv | 144 ++++++++++++++
 tb/tb_regfile_wb_queue.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_queue.sv
// Write-back queue: two-input in-order FIFO feeding the register file port.
// Optional forwarding lookup enabled by defining WB_FORWARD_EN.
module regfile_wb_queue #(
  parameter int XLEN  = 64,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       mem_valid,
  input  logic [4:0]                 mem_rd,
  input  logic [XLEN-1:0]            mem_data,
  output logic                       mem_ready,
  input  logic                       alu_valid,
  input  logic [4:0]                 alu_rd,
  input  logic [XLEN-1:0]            alu_data,
  output logic                       alu_ready,
  output logic                       wr_en,
  output logic [4:0]                 wr_rd,
  output logic [XLEN-1:0]            wr_data,
  input  logic [4:0]                 fwd_rs,
  output logic                       fwd_hit,
  output logic [XLEN-1:0]            fwd_data,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  localparam logic [CW-1:0] C_M1 = CW'(DEPTH - 1);
  localparam logic [CW-1:0] C_M2 = CW'(DEPTH - 2);

  logic [4:0]      r_rd   [DEPTH];
  logic [XLEN-1:0] r_data [DEPTH];
  logic [PW-1:0]   r_head;
  logic [PW-1:0]   r_tail;
  logic [CW-1:0]   r_count;
  logic            r_wr_en;
  logic [4:0]      r_wr_rd;
  logic [XLEN-1:0] r_wr_data;

  logic            w_mem_ready;
  logic            w_alu_ready;
  logic            w_mem_enq;
  logic            w_alu_enq;
  logic            w_pop;
  logic [PW-1:0]   w_alu_slot;
  logic [CW-1:0]   w_count_nxt;
  logic            w_fwd_hit;
  logic [XLEN-1:0] w_fwd_data;

  function automatic logic [PW-1:0] wrap_add(
    input logic [PW-1:0] a,
    input int unsigned   b
  );
    int unsigned s;
    s = (32'(a) + b) % DEPTH;
    return PW'(s);
  endfunction

  // Readiness looks only at the registered count, never at this cycle's pop.
  assign w_mem_ready = (r_count <= C_M1);
  assign w_alu_ready = (r_count <= C_M2) ||
                       ((r_count == C_M1) && !mem_valid);

  assign w_mem_enq = mem_valid && w_mem_ready && (mem_rd != 5'd0);
  assign w_alu_enq = alu_valid && w_alu_ready && (alu_rd != 5'd0);
  assign w_pop     = (r_count != '0);

  assign w_alu_slot  = wrap_add(r_tail, 32'(w_mem_enq));
  assign w_count_nxt = r_count + CW'(w_mem_enq) + CW'(w_alu_enq)
                     - CW'(w_pop);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_head    <= '0;
      r_tail    <= '0;
      r_count   <= '0;
      r_wr_en   <= 1'b0;
      r_wr_rd   <= '0;
      r_wr_data <= '0;
    end else begin
      r_head  <= wrap_add(r_head, 32'(w_pop));
      r_tail  <= wrap_add(r_tail, 32'(w_mem_enq) + 32'(w_alu_enq));
      r_count <= w_count_nxt;
      if (w_pop) begin
        r_wr_en   <= 1'b1;
        r_wr_rd   <= r_rd[r_head];
        r_wr_data <= r_data[r_head];
      end else begin
        r_wr_en   <= 1'b0;
      end
    end
  end

  // Entry storage is never cleared; pointers and count define validity.
  always_ff @(posedge clk) begin
    if (w_mem_enq) begin
      r_rd[r_tail]   <= mem_rd;
      r_data[r_tail] <= mem_data;
    end
    if (w_alu_enq) begin
      r_rd[w_alu_slot]   <= alu_rd;
      r_data[w_alu_slot] <= alu_data;
    end
  end

`ifdef WB_FORWARD_EN
  always_comb begin
    w_fwd_hit  = 1'b0;
    w_fwd_data = '0;
    // Oldest to youngest, so the last match wins.
    for (int k = 0; k < DEPTH; k++) begin
      if ((CW'(k) < r_count) &&
          (r_rd[wrap_add(r_head, 32'(k))] == fwd_rs)) begin
        w_fwd_hit  = 1'b1;
        w_fwd_data = r_data[wrap_add(r_head, 32'(k))];
      end
    end
    if (!w_fwd_hit && r_wr_en && (r_wr_rd == fwd_rs)) begin
      w_fwd_hit  = 1'b1;
      w_fwd_data = r_wr_data;
    end
    if (fwd_rs == 5'd0) begin
      w_fwd_hit  = 1'b0;
      w_fwd_data = '0;
    end
  end
`else
  logic w_unused_fwd;
  assign w_unused_fwd = ^fwd_rs;
  assign w_fwd_hit    = 1'b0;
  assign w_fwd_data   = '0;
`endif

  assign mem_ready = w_mem_ready;
  assign alu_ready = w_alu_ready;
  assign wr_en     = r_wr_en;
  assign wr_rd     = r_wr_rd;
  assign wr_data   = r_wr_data;
  assign fwd_hit   = w_fwd_hit;
  assign fwd_data  = w_fwd_data;
  assign count     = r_count;

endmodule

// File: tb/tb_regfile_wb_queue.sv
// Directed self-checking bench for regfile_wb_queue.
// Forwarding expectations follow WB_FORWARD_EN.
module tb_regfile_wb_queue;

  localparam int XLEN  = 64;
  localparam int DEPTH = 4;
`ifdef WB_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic            clk;
  logic            reset;
  logic            mem_valid;
  logic [4:0]      mem_rd;
  logic [XLEN-1:0] mem_data;
  logic            mem_ready;
  logic            alu_valid;
  logic [4:0]      alu_rd;
  logic [XLEN-1:0] alu_data;
  logic            alu_ready;
  logic            wr_en;
  logic [4:0]      wr_rd;
  logic [XLEN-1:0] wr_data;
  logic [4:0]      fwd_rs;
  logic            fwd_hit;
  logic [XLEN-1:0] fwd_data;
  logic [$clog2(DEPTH+1)-1:0] count;

  typedef struct {
    logic [4:0]      rd;
    logic [XLEN-1:0] d;
  } ent_t;

  int   n_cmp;
  int   n_err;
  int   mc;
  bit   mr;
  bit   ar;
  bit   pe;
  ent_t e;
  ent_t q[$];

  regfile_wb_queue #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .mem_valid(mem_valid), .mem_rd(mem_rd),
    .mem_data(mem_data), .mem_ready(mem_ready),
    .alu_valid(alu_valid), .alu_rd(alu_rd),
    .alu_data(alu_data), .alu_ready(alu_ready),
    .wr_en(wr_en), .wr_rd(wr_rd), .wr_data(wr_data),
    .fwd_rs(fwd_rs), .fwd_hit(fwd_hit),
    .fwd_data(fwd_data), .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout required finish");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_fwd(input string tag, input bit h,
                         input logic [63:0] d);
    chk({tag, "_hit"}, 64'(fwd_hit), 64'(FWD & h));
    chk({tag, "_data"}, fwd_data, (FWD && h) ? d : 64'd0);
  endtask

  // One cycle of the scoreboard-driven stream; inputs already driven.
  task automatic stream_step(input string tag);
    mid();
    mr = (mc <= DEPTH - 1);
    ar = (mc <= DEPTH - 2) || ((mc == DEPTH - 1) && !mem_valid);
    chk({tag, "_count"}, 64'(count), 64'(mc));
    chk({tag, "_mem_ready"}, 64'(mem_ready), 64'(mr));
    chk({tag, "_alu_ready"}, 64'(alu_ready), 64'(ar));
    pe = (mc > 0);
    if (pe) e = q.pop_front();
    if (mem_valid && mr && mem_rd != 0) q.push_back('{mem_rd, mem_data});
    if (alu_valid && ar && alu_rd != 0) q.push_back('{alu_rd, alu_data});
    mc = q.size();
    tick();
    chk({tag, "_wr_en"}, 64'(wr_en), 64'(pe));
    if (pe) begin
      chk({tag, "_wr_rd"}, 64'(wr_rd), 64'(e.rd));
      chk({tag, "_wr_data"}, wr_data, e.d);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    reset = 1'b1;
    mem_valid = 1'b0; mem_rd = '0; mem_data = '0;
    alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
    fwd_rs = 5'd0;

    tick();
    tick();
    fwd_rs = 5'd5;
    mid();
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_wr_en", 64'(wr_en), 64'd0);
    chk("rst_wr_rd", 64'(wr_rd), 64'd0);
    chk("rst_wr_data", wr_data, 64'd0);
    chk("rst_mem_ready", 64'(mem_ready), 64'd1);
    chk("rst_alu_ready", 64'(alu_ready), 64'd1);
    chk("rst_fwd_hit", 64'(fwd_hit), 64'd0);
    chk("rst_fwd_data", fwd_data, 64'd0);
    tick();
    reset = 1'b0;

    // Single ALU write.
    alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 64'h1234;
    mid();
    chk("one_alu_ready", 64'(alu_ready), 64'd1);
    chk_fwd("one_incoming", 1'b0, 64'd0);
    tick();
    alu_valid = 1'b0;
    mid();
    chk("one_count1", 64'(count), 64'd1);
    chk("one_wr_en0", 64'(wr_en), 64'd0);
    chk_fwd("one_fwd_q", 1'b1, 64'h1234);
    tick();
    mid();
    chk("one_wr_en1", 64'(wr_en), 64'd1);
    chk("one_wr_rd", 64'(wr_rd), 64'd5);
    chk("one_wr_data", wr_data, 64'h1234);
    chk("one_count0", 64'(count), 64'd0);
    chk_fwd("one_fwd_wr", 1'b1, 64'h1234);
    tick();
    mid();
    chk("one_wr_en_off", 64'(wr_en), 64'd0);
    chk("one_wr_rd_hold", 64'(wr_rd), 64'd5);
    chk_fwd("one_fwd_miss", 1'b0, 64'd0);

    // Dual accept: mem older than alu, same rd.
    tick();
    fwd_rs = 5'd3;
    mem_valid = 1'b1; mem_rd = 5'd3; mem_data = 64'hA;
    alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 64'hB;
    mid();
    chk("dual_mem_ready", 64'(mem_ready), 64'd1);
    chk("dual_alu_ready", 64'(alu_ready), 64'd1);
    tick();
    mem_valid = 1'b0; alu_valid = 1'b0;
    mid();
    chk("dual_count2", 64'(count), 64'd2);
    chk_fwd("dual_fwd2", 1'b1, 64'hB);
    tick();
    mid();
    chk("dual_w1_en", 64'(wr_en), 64'd1);
    chk("dual_w1_data", wr_data, 64'hA);
    chk("dual_count1", 64'(count), 64'd1);
    chk_fwd("dual_fwd1", 1'b1, 64'hB);
    tick();
    mid();
    chk("dual_w2_en", 64'(wr_en), 64'd1);
    chk("dual_w2_rd", 64'(wr_rd), 64'd3);
    chk("dual_w2_data", wr_data, 64'hB);
    chk_fwd("dual_fwd_wr", 1'b1, 64'hB);
    tick();
    mid();
    chk("dual_done", 64'(wr_en), 64'd0);
    chk_fwd("dual_fwd_miss", 1'b0, 64'd0);
    tick();

    // Sustained dual traffic with backpressure and pointer wrap.
    mc = 0;
    q.delete();
    for (int c = 0; c < 14; c++) begin
      mem_valid = ((c % 3) != 2);
      mem_rd    = 5'(1 + c);
      mem_data  = 64'h1000 + 64'(c);
      alu_valid = 1'b1;
      alu_rd    = 5'(16 + c);
      alu_data  = 64'h2000 + 64'(c);
      stream_step("bp");
    end
    mem_valid = 1'b0;
    alu_valid = 1'b0;
    for (int c = 0; c < 5; c++) stream_step("drain");
    chk("drain_empty", 64'(count), 64'd0);

    // x0 handshake is accepted but never written.
    fwd_rs = 5'd0;
    alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 64'hFF;
    mid();
    chk("x0_alu_ready", 64'(alu_ready), 64'd1);
    chk("x0_fwd_hit", 64'(fwd_hit), 64'd0);
    tick();
    alu_valid = 1'b0;
    mid();
    chk("x0_count", 64'(count), 64'd0);
    chk("x0_wr_en_a", 64'(wr_en), 64'd0);
    tick();
    mid();
    chk("x0_wr_en_b", 64'(wr_en), 64'd0);
    tick();

    // Reset while three writes are pending.
    mem_valid = 1'b1; mem_rd = 5'd7; mem_data = 64'h77;
    alu_valid = 1'b1; alu_rd = 5'd8; alu_data = 64'h88;
    tick();
    mem_rd = 5'd9; mem_data = 64'h99;
    alu_rd = 5'd10; alu_data = 64'hAA;
    mid();
    chk("rm_count2", 64'(count), 64'd2);
    tick();
    mem_valid = 1'b0; alu_valid = 1'b0;
    mid();
    chk("rm_count3", 64'(count), 64'd3);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    fwd_rs = 5'd9;
    mid();
    chk("rm_count0", 64'(count), 64'd0);
    chk("rm_wr_en", 64'(wr_en), 64'd0);
    chk("rm_wr_rd", 64'(wr_rd), 64'd0);
    chk("rm_wr_data", wr_data, 64'd0);
    chk("rm_mem_ready", 64'(mem_ready), 64'd1);
    chk_fwd("rm_fwd", 1'b0, 64'd0);
    tick();
    mid();
    chk("rm_no_stale_a", 64'(wr_en), 64'd0);
    chk("rm_count_a", 64'(count), 64'd0);
    tick();
    mid();
    chk("rm_no_stale_b", 64'(wr_en), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
